// File: rtl/bucket_sort_pkg.sv
// bucket_sort_pkg
//   Shared definitions for the bucket-sort accelerator: the controller state
//   encoding, the bucket index width and the key-to-bucket mapping.
//   BUCKET_W follows DEF_NUM_BUCKETS. A design that wants a different bucket
//   count changes DEF_NUM_BUCKETS here so that the index width tracks it.
package bucket_sort_pkg;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_NUM_BUCKETS = 10;
    localparam int DEF_KEY_SHIFT   = 4;
    localparam int BUCKET_W        = $clog2(DEF_NUM_BUCKETS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_HIST_RD,
        ST_HIST_ACC,
        ST_COUNT_WR,
        ST_SCAT_RD,
        ST_SCAT_WR,
        ST_DONE
    } state_t;

    // Keys are unsigned. A key selects bucket key >> keyShift, and any key
    // beyond the last bucket is folded into the last bucket.
    function automatic logic [BUCKET_W-1:0] bucket_of(
        input logic [DEF_DATA_W-1:0] key,
        input int                    keyShift,
        input int                    numBuckets
    );
        logic [DEF_DATA_W-1:0] shifted;
        shifted = key >> keyShift;
        if (shifted >= DEF_DATA_W'(numBuckets))
            return BUCKET_W'(numBuckets - 1);
        else
            return shifted[BUCKET_W-1:0];
    endfunction

endpackage

// File: rtl/bucket_sort_engine_table.sv
// bucket_table
//   Per-bucket register files for the sort engine. counts[] holds the
//   histogram and offs[] holds the next destination slot of each bucket.
//   Ports:
//     clk, reset   clock and synchronous active-high reset
//     i_clr        zero counts[i_idx] and restart the running prefix sum
//     i_inc        counts[i_idx]++
//     i_pfx        offs[i_idx] = running sum, then running sum += counts[i_idx]
//     i_offInc     offs[i_idx]++
//     i_idx        bucket addressed by every operation and by both outputs
//     o_count      counts[i_idx]
//     o_offs       offs[i_idx]
module bucket_table
    import bucket_sort_pkg::*;
#(
    parameter int NUM_BUCKETS = DEF_NUM_BUCKETS,
    parameter int CNT_W       = 9
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_clr,
    input  logic                i_inc,
    input  logic                i_pfx,
    input  logic                i_offInc,
    input  logic [BUCKET_W-1:0] i_idx,
    output logic [CNT_W-1:0]    o_count,
    output logic [CNT_W-1:0]    o_offs
);

    logic [CNT_W-1:0] r_counts [NUM_BUCKETS];
    logic [CNT_W-1:0] r_offs   [NUM_BUCKETS];
    logic [CNT_W-1:0] r_runSum;

    // The controller only requests one operation per cycle, so the branches
    // below never compete for the same entry. The running sum is restarted
    // during the clear sweep. That way the prefix sweep that follows the
    // histogram always starts from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NUM_BUCKETS; b++) begin
                r_counts[b] <= '0;
                r_offs[b]   <= '0;
            end
            r_runSum <= '0;
        end else begin
            if (i_clr) begin
                r_counts[i_idx] <= '0;
                r_runSum        <= '0;
            end
            if (i_inc)
                r_counts[i_idx] <= r_counts[i_idx] + CNT_W'(1);
            if (i_pfx) begin
                r_offs[i_idx] <= r_runSum;
                r_runSum      <= r_runSum + r_counts[i_idx];
            end
            if (i_offInc)
                r_offs[i_idx] <= r_offs[i_idx] + CNT_W'(1);
        end
    end

    assign o_count = r_counts[i_idx];
    assign o_offs  = r_offs[i_idx];

endmodule

// File: rtl/bucket_sort_engine.sv
// bucket_sort_engine
//   Counting/bucket-sort accelerator that masters the data memory. The sort
//   runs in four phases:
//     1. clear the histogram;
//     2. histogram the source keys;
//     3. write out the counts while building the exclusive prefix offsets;
//     4. scatter each element, stably, into the destination array.
//   Ports:
//     clk, reset                  clock, synchronous active-high reset
//     start                       one-cycle request, honoured only when idle
//     src_base/dst_base/cnt_base  word addresses of source, result, counts
//     len                         element count (must not exceed N_MAX)
//     busy                        an accepted sort is in progress
//     done                        one-cycle completion pulse
//     err                         sticky length error, cleared by a good start
//     mem_en/mem_we/mem_addr/mem_wdata/mem_rdata
//                                 single-port memory master; read data
//                                 arrives one cycle after the request
module bucket_sort_engine
    import bucket_sort_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int NUM_BUCKETS = DEF_NUM_BUCKETS,
    parameter int KEY_SHIFT   = DEF_KEY_SHIFT,
    parameter int N_MAX       = 256,
    parameter int CNT_W       = 9
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W-1:0] cnt_base,
    input  logic [CNT_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t              r_state;
    state_t              w_nextState;
    logic [ADDR_W-1:0]   r_srcBase;
    logic [ADDR_W-1:0]   r_dstBase;
    logic [ADDR_W-1:0]   r_cntBase;
    logic [CNT_W-1:0]    r_len;
    logic [CNT_W-1:0]    r_idx;
    logic [BUCKET_W-1:0] r_bkt;
    logic                r_scatLatch;
    logic [DATA_W-1:0]   r_elem;
    logic [BUCKET_W-1:0] r_elemBkt;
    logic                r_done;
    logic                r_err;

    logic                w_tblClr;
    logic                w_tblInc;
    logic                w_tblPfx;
    logic                w_tblOffInc;
    logic [BUCKET_W-1:0] w_tblIdx;
    logic [CNT_W-1:0]    w_count;
    logic [CNT_W-1:0]    w_offs;
    logic [BUCKET_W-1:0] w_rdBkt;
    logic                w_lastBkt;
    logic                w_lastElem;
    logic                w_lenBad;
    logic                w_memEn;
    logic                w_memWe;
    logic [ADDR_W-1:0]   w_memAddr;
    logic [DATA_W-1:0]   w_memWdata;

    bucket_table #(
        .NUM_BUCKETS (NUM_BUCKETS),
        .CNT_W       (CNT_W)
    ) u_table (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (w_tblClr),
        .i_inc    (w_tblInc),
        .i_pfx    (w_tblPfx),
        .i_offInc (w_tblOffInc),
        .i_idx    (w_tblIdx),
        .o_count  (w_count),
        .o_offs   (w_offs)
    );

    assign w_rdBkt    = bucket_of(DEF_DATA_W'(mem_rdata), KEY_SHIFT, NUM_BUCKETS);
    assign w_lastBkt  = (r_bkt == BUCKET_W'(NUM_BUCKETS - 1));
    assign w_lastElem = ((r_idx + CNT_W'(1)) >= r_len);
    assign w_lenBad   = (len > CNT_W'(N_MAX));

    // Next-state and per-state control. The memory request and the table
    // operation are decoded from the current state, so a read issued in
    // HIST_RD or the first SCAT_RD cycle has its data on mem_rdata in the
    // following cycle. SCAT_RD lasts two cycles. The first cycle issues the
    // read. The second, with r_scatLatch set, only captures the returned
    // element.
    always_comb begin
        w_nextState = r_state;
        w_tblClr    = 1'b0;
        w_tblInc    = 1'b0;
        w_tblPfx    = 1'b0;
        w_tblOffInc = 1'b0;
        w_tblIdx    = r_bkt;
        w_memEn     = 1'b0;
        w_memWe     = 1'b0;
        w_memAddr   = '0;
        w_memWdata  = '0;
        case (r_state)
            ST_IDLE: begin
                if (start)
                    w_nextState = w_lenBad ? ST_DONE : ST_CLEAR;
            end
            ST_CLEAR: begin
                w_tblClr = 1'b1;
                if (w_lastBkt)
                    w_nextState = (r_len == '0) ? ST_COUNT_WR : ST_HIST_RD;
            end
            ST_HIST_RD: begin
                w_memEn     = 1'b1;
                w_memAddr   = r_srcBase + ADDR_W'(r_idx);
                w_nextState = ST_HIST_ACC;
            end
            ST_HIST_ACC: begin
                w_tblInc    = 1'b1;
                w_tblIdx    = w_rdBkt;
                w_nextState = w_lastElem ? ST_COUNT_WR : ST_HIST_RD;
            end
            ST_COUNT_WR: begin
                w_memEn    = 1'b1;
                w_memWe    = 1'b1;
                w_memAddr  = r_cntBase + ADDR_W'(r_bkt);
                w_memWdata = DATA_W'(w_count);
                w_tblPfx   = 1'b1;
                if (w_lastBkt)
                    w_nextState = (r_len == '0) ? ST_DONE : ST_SCAT_RD;
            end
            ST_SCAT_RD: begin
                if (!r_scatLatch) begin
                    w_memEn   = 1'b1;
                    w_memAddr = r_srcBase + ADDR_W'(r_idx);
                end else begin
                    w_nextState = ST_SCAT_WR;
                end
            end
            ST_SCAT_WR: begin
                w_memEn     = 1'b1;
                w_memWe     = 1'b1;
                w_tblIdx    = r_elemBkt;
                w_memAddr   = r_dstBase + ADDR_W'(w_offs);
                w_memWdata  = r_elem;
                w_tblOffInc = 1'b1;
                w_nextState = w_lastElem ? ST_DONE : ST_SCAT_RD;
            end
            ST_DONE: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // State register plus the datapath registers. The completion pulse is
    // registered from the DONE state, so it appears one cycle after DONE.
    // A rejected start sets err and passes through DONE without touching
    // the latched operands.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_srcBase   <= '0;
            r_dstBase   <= '0;
            r_cntBase   <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_bkt       <= '0;
            r_scatLatch <= 1'b0;
            r_elem      <= '0;
            r_elemBkt   <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_done  <= (r_state == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_lenBad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_err       <= 1'b0;
                            r_srcBase   <= src_base;
                            r_dstBase   <= dst_base;
                            r_cntBase   <= cnt_base;
                            r_len       <= len;
                            r_idx       <= '0;
                            r_bkt       <= '0;
                            r_scatLatch <= 1'b0;
                        end
                    end
                end
                ST_CLEAR: begin
                    r_bkt <= w_lastBkt ? '0 : r_bkt + BUCKET_W'(1);
                end
                ST_HIST_ACC: begin
                    r_idx <= r_idx + CNT_W'(1);
                end
                ST_COUNT_WR: begin
                    if (w_lastBkt) begin
                        r_bkt <= '0;
                        r_idx <= '0;
                    end else begin
                        r_bkt <= r_bkt + BUCKET_W'(1);
                    end
                end
                ST_SCAT_RD: begin
                    if (r_scatLatch) begin
                        r_elem      <= mem_rdata;
                        r_elemBkt   <= w_rdBkt;
                        r_scatLatch <= 1'b0;
                    end else begin
                        r_scatLatch <= 1'b1;
                    end
                end
                ST_SCAT_WR: begin
                    r_idx <= r_idx + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done      = r_done;
    assign err       = r_err;
    assign mem_en    = w_memEn;
    assign mem_we    = w_memWe;
    assign mem_addr  = w_memAddr;
    assign mem_wdata = w_memWdata;

endmodule

// File: tb/tb_bucket_sort_engine.sv
// tb_bucket_sort_engine
//   Self-checking bench for bucket_sort_engine. It attaches a word memory
//   model to the engine and runs table-driven directed sorts, randomized
//   sorts against a reference model, and hand-written sequences for the
//   length-error, reset-abort and start-while-busy cases.
module tb_bucket_sort_engine;

    localparam int NB     = 10;
    localparam int N_MAX  = 256;
    localparam int CNT_W  = 9;
    localparam int SRC    = 0;
    localparam int DST    = 400;
    localparam int CNTB   = 800;
    localparam int LIMIT  = 3000;
    localparam logic [31:0] SENT = 32'hDEADBEEF;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [9:0]        src_base;
    logic [9:0]        dst_base;
    logic [9:0]        cnt_base;
    logic [CNT_W-1:0]  len;
    logic              busy;
    logic              done;
    logic              err;
    logic              mem_en;
    logic              mem_we;
    logic [9:0]        mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    always #5 clk = ~clk;

    bucket_sort_engine dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .src_base  (src_base),
        .dst_base  (dst_base),
        .cnt_base  (cnt_base),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    logic [31:0] mem [1024];
    int readCount, writeCount, enCount, doneCount;

    // Single-port memory with one cycle of read latency. It also tallies
    // the traffic and the done pulses so the bench can check them.
    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            enCount++;
            if (mem_we) begin
                mem[mem_addr] = mem_wdata;
                writeCount++;
            end else begin
                mem_rdata <= mem[mem_addr];
                readCount++;
            end
        end
        if (done === 1'b1)
            doneCount++;
    end

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] keys   [N_MAX];
    int          expCnt [NB];
    logic [31:0] expDst [N_MAX];
    int          runCycles;
    logic        errAfterStart;

    typedef struct {
        int                   n;
        logic [0:7][31:0]     k;
        logic [0:NB-1][8:0]   c;
        logic [0:7][31:0]     d;
        int                   cyc;
    } vec_t;
    vec_t vecs [3];

    // Records one comparison and reports it if it does not hold.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference bucket of a key: integer divide by 16, folded into the last bucket.
    function automatic int refBucket(input logic [31:0] k);
        int q;
        q = int'(k / 32'd16);
        return (q > NB - 1) ? NB - 1 : q;
    endfunction

    // Builds the expected counts and the sorted output. It walks the buckets
    // in order and, within each bucket, the keys in input order.
    task automatic computeModel(input int n);
        int pos = 0;
        for (int b = 0; b < NB; b++) expCnt[b] = 0;
        for (int b = 0; b < NB; b++)
            for (int j = 0; j < n; j++)
                if (refBucket(keys[j]) == b) begin
                    expDst[pos] = keys[j];
                    pos++;
                    expCnt[b]++;
                end
    endtask

    task automatic loadMemory(input int n);
        for (int j = 0; j < n; j++) mem[SRC + j] = keys[j];
        for (int j = 0; j <= N_MAX; j++) mem[DST + j] = SENT;
        for (int b = 0; b < NB; b++) mem[CNTB + b] = SENT;
    endtask

    // Pulses start and waits, with a cycle budget, for done. runCycles
    // counts clock edges after the edge that sampled start. When intrudeAt
    // is non-zero, a second start with a different length is pulsed at that
    // cycle, while the engine is still busy.
    task automatic applyStimulus(input int n, input int intrudeAt);
        @(negedge clk);
        readCount = 0; writeCount = 0; enCount = 0; doneCount = 0;
        src_base = 10'(SRC); dst_base = 10'(DST); cnt_base = 10'(CNTB);
        len = CNT_W'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        errAfterStart = err;
        runCycles = 0;
        while (done !== 1'b1 && runCycles < LIMIT) begin
            @(posedge clk); #1;
            runCycles++;
            if (intrudeAt != 0 && runCycles == intrudeAt) begin
                start = 1'b1;
                len = CNT_W'(3);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (done !== 1'b1) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL done timeout: got no done after %0d cycles, expected done", LIMIT);
        end
    endtask

    task automatic verifyRun(input string tag, input int n, input int expCycles);
        checkOutput({tag, " latency"}, runCycles, expCycles);
        @(posedge clk); #1;
        checkOutput({tag, " done width"}, {31'd0, done}, 0);
        for (int b = 0; b < NB; b++)
            checkOutput($sformatf("%s cnt[%0d]", tag, b), mem[CNTB + b], expCnt[b]);
        for (int j = 0; j < n; j++)
            checkOutput($sformatf("%s dst[%0d]", tag, j), mem[DST + j], expDst[j]);
        checkOutput({tag, " dst guard"}, mem[DST + n], SENT);
        checkOutput({tag, " reads"}, readCount, 2 * n);
        checkOutput({tag, " writes"}, writeCount, NB + n);
    endtask

    task automatic loadVector(input int v);
        for (int j = 0; j < 8; j++) begin
            keys[j]   = vecs[v].k[j];
            expDst[j] = vecs[v].d[j];
        end
        for (int b = 0; b < NB; b++) expCnt[b] = int'(vecs[v].c[b]);
        loadMemory(vecs[v].n);
    endtask

    initial begin
        vecs[0].n   = 8;
        vecs[0].k   = '{32'h35, 32'h12, 32'h07, 32'h98, 32'h12, 32'hF3, 32'h21, 32'h05};
        vecs[0].c   = '{9'd2, 9'd2, 9'd1, 9'd1, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd2};
        vecs[0].d   = '{32'h07, 32'h05, 32'h12, 32'h12, 32'h21, 32'h35, 32'h98, 32'hF3};
        vecs[0].cyc = 61;
        vecs[1].n   = 3;
        vecs[1].k   = '{32'hFFFFFFFF, 32'h000000A0, 32'h0000FFFF, 0, 0, 0, 0, 0};
        vecs[1].c   = '{9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd3};
        vecs[1].d   = '{32'hFFFFFFFF, 32'h000000A0, 32'h0000FFFF, 0, 0, 0, 0, 0};
        vecs[1].cyc = 36;
        vecs[2].n   = 0;
        vecs[2].k   = '{0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2].c   = '{9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0};
        vecs[2].d   = '{0, 0, 0, 0, 0, 0, 0, 0};
        vecs[2].cyc = 21;

        // Reset state.
        reset = 1'b1; start = 1'b0; len = '0;
        src_base = '0; dst_base = '0; cnt_base = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", {31'd0, busy}, 0);
        checkOutput("reset done", {31'd0, done}, 0);
        checkOutput("reset err", {31'd0, err}, 0);
        checkOutput("reset mem_en", {31'd0, mem_en}, 0);
        checkOutput("reset mem_we", {31'd0, mem_we}, 0);
        checkOutput("reset mem_addr", {22'd0, mem_addr}, 0);
        checkOutput("reset mem_wdata", mem_wdata, 0);
        @(negedge clk);
        reset = 1'b0;

        // Directed table: sample sort, clamp/stability, empty array.
        for (int v = 0; v < 3; v++) begin
            loadVector(v);
            applyStimulus(vecs[v].n, 0);
            verifyRun($sformatf("vec%0d", v), vecs[v].n, vecs[v].cyc);
        end

        // Oversized length: flagged, done two edges later, memory untouched.
        @(negedge clk);
        enCount = 0;
        len = CNT_W'(N_MAX + 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("lenerr err", {31'd0, err}, 1);
        checkOutput("lenerr done early", {31'd0, done}, 0);
        checkOutput("lenerr busy", {31'd0, busy}, 0);
        @(posedge clk); #1;
        checkOutput("lenerr done", {31'd0, done}, 1);
        @(posedge clk); #1;
        checkOutput("lenerr done width", {31'd0, done}, 0);
        checkOutput("lenerr sticky", {31'd0, err}, 1);
        checkOutput("lenerr mem_en", enCount, 0);
        loadVector(2);
        applyStimulus(0, 0);
        checkOutput("lenerr cleared", {31'd0, errAfterStart}, 0);
        verifyRun("after_err", 0, 21);

        // Reset sampled at cycle 20 of a sort, then a clean rerun.
        loadVector(0);
        @(negedge clk);
        len = CNT_W'(8);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort busy", {31'd0, busy}, 0);
        checkOutput("abort mem_en", {31'd0, mem_en}, 0);
        enCount = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("abort quiet", enCount, 0);
        loadVector(0);
        applyStimulus(8, 0);
        verifyRun("post_abort", 8, 61);

        // A start while busy must be ignored.
        loadVector(0);
        applyStimulus(8, 10);
        verifyRun("busy_start", 8, 61);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("busy_start done count", doneCount, 1);

        // Randomized sorts against the reference model; last one at N_MAX.
        for (int r = 0; r < 6; r++) begin
            int n;
            n = (r == 5) ? N_MAX : int'($urandom_range(1, 40));
            for (int j = 0; j < n; j++)
                keys[j] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 191));
            computeModel(n);
            loadMemory(n);
            applyStimulus(n, 0);
            verifyRun($sformatf("rand%0d", r), n, 2 * NB + 5 * n + 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/bucket_sort_engine.md
Name: bucket_sort_engine

Overview:
Memory-mapped hardware counting/bucket-sort accelerator for the Mini-MIPS data memory. It replaces the software bucket-sort kernel. Given a source array base, a destination base, a bucket-count base and a length, it:
- histograms the keys into NUM_BUCKETS buckets;
- writes the per-bucket counts back to memory;
- scatters the elements into the destination array, stably, in bucket order.

It sits beside dm as a second master on a single-port word-addressed data-memory interface.

Parameters:
DATA_W, 32, element/word width
ADDR_W, 10, word-address width of data memory
NUM_BUCKETS, 10, bucket count (2..64)
KEY_SHIFT, 4, bucket = key >> KEY_SHIFT, clamped to NUM_BUCKETS-1
N_MAX, 256, maximum accepted len
CNT_W, 9, counter width; must satisfy 2^CNT_W > N_MAX

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; sampled only in IDLE
src_base  in  ADDR_W  word address of element 0 of the input array
dst_base  in  ADDR_W  word address of the sorted output
cnt_base  in  ADDR_W  word address of bucket-count table
len  in  CNT_W  number of elements
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse at completion
err  out  1  sticky until next accepted start; set when len > N_MAX
mem_en  out  1  memory request valid
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  word address
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after a read request

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. While reset=1, at the next clk edge:
  - state is forced to IDLE;
  - busy, done, err, mem_en, mem_we are driven 0; mem_addr and mem_wdata are driven 0;
  - counts[] and offs[] are cleared.
- Reset mid-operation: the operation is abandoned, and there are no memory requests from the cycle after reset is sampled.
- Keys are unsigned. bucket(k) = min(k >> KEY_SHIFT, NUM_BUCKETS-1).
- FSM states: IDLE, CLEAR, HIST_RD, HIST_ACC, COUNT_WR, SCAT_RD, SCAT_WR, DONE.
- IDLE:
  - start=1 and len<=N_MAX: latch the bases and len, clear err, go to CLEAR.
  - start=1 and len>N_MAX: set err, go to DONE with no memory access.
  - start while busy is ignored.
- CLEAR: NUM_BUCKETS cycles; zero counts[b] one bucket per cycle.
- Histogram pass (2 cycles per element):
  - HIST_RD issues a read of src_base+i.
  - HIST_ACC does counts[bucket(rdata)]++ and i++. Return to HIST_RD while i<len, else go to COUNT_WR.
  - len=0 goes from CLEAR straight to COUNT_WR.
- COUNT_WR: NUM_BUCKETS cycles. Cycle b:
  - write counts[b], zero-extended to DATA_W, to cnt_base+b;
  - set offs[b] = exclusive prefix sum of counts[0..b-1].
  - Then go to SCAT_RD, or to DONE if len=0.
- Scatter pass (3 cycles per element), i restarts at 0:
  - SCAT_RD issues a read of src_base+i.
  - The next cycle latches rdata and its bucket b.
  - SCAT_WR writes the element to dst_base+offs[b], then offs[b]++ and i++.
  - Loop while i<len; elements therefore land in stable order.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Latency: with a valid len, done is high exactly 2*NUM_BUCKETS + 5*len + 1 cycles after the start edge.
- mem_en is high only in HIST_RD, COUNT_WR, SCAT_RD and SCAT_WR. mem_we is high only in COUNT_WR and SCAT_WR.
- Address arithmetic wraps modulo 2^ADDR_W. Overlapping regions are not checked, and the result is undefined if regions overlap.
- Counter overflow cannot occur, because len <= N_MAX < 2^CNT_W.

Decomposition:
- Package bucket_sort_pkg holds:
  - the state enum;
  - the BUCKET_W = clog2(NUM_BUCKETS) localparam;
  - the bucket_of() function, which does the shift and clamp.
- One natural sub-module, bucket_table: NUM_BUCKETS x CNT_W counts and offs register files, with clear, increment and prefix-accumulate ports. It is instantiated once.
- The FSM and the memory muxing stay in the top.

Test Plan:
- Sort with NB=10, KEY_SHIFT=4:
  - Stimulus: src=[0x35,0x12,0x07,0x98,0x12,0xF3,0x21,0x05], len=8.
  - Counts written to cnt_base..+9 = [2,2,1,1,0,0,0,0,0,2].
  - dst = [0x07,0x05,0x12,0x12,0x21,0x35,0x98,0xF3].
  - done exactly 61 cycles after start.
- len=0 -> 10 count writes, all zero; no reads; done after 21 cycles; dst untouched.
- len=N_MAX+1 -> err=1 and done pulse the cycle after next; mem_en never asserted; err clears on next valid start.
- Stability and clamp:
  - Stimulus: keys 0xFFFFFFFF, 0x000000A0, 0x0000FFFF (all map to bucket 9), len=3.
  - dst keeps input order; count[9]=3.
- Reset at cycle 20 of a len=8 run -> busy=0 and mem_en=0 from the next cycle. A fresh start then completes correctly in 61 cycles.
- start pulsed while busy -> ignored; exactly one done pulse; counts unchanged from the single-run values.
